lane_deserializer: RTL and testbench

- Receive-side per-lane serial-to-parallel stage. Sits directly upstream of mux_striping; one instance per lane drives lane_0/valid_0 and lane_1/valid_1.
- Hunts for the COM symbol (0xBC) in the incoming bit stream and locks byte alignment after COM_LOCK consecutive aligned commas.
- After lock, assembles 32-bit words MSB-first and presents each with a valid flag. Idle words (four COMs) are flagged not-valid.

---
 rtl/lane_deserializer.sv | 144 ++++++++++++++
 tb/tb_lane_deserializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lane_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : lane_deserializer
// Description : Per-lane serial-to-parallel receiver. Hunts for the comma
//               symbol, locks byte alignment after COM_LOCK aligned commas,
//               then assembles MSB-first words and flags idle words.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_deserializer #(
  parameter int         WORD_W   = 32,
  parameter logic [7:0] COM      = 8'hBC,
  parameter int         COM_LOCK = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [WORD_W-1:0] lane_out,
  output logic              valid_out,
  output logic              word_strobe,
  output logic              active
);

  localparam int                WCNT_W    = $clog2(WORD_W);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORD_W - 1);
  localparam logic [3:0]        LOCK_N    = 4'(COM_LOCK);
  localparam logic [WORD_W-1:0] IDLE_WORD = {WORD_W/8{COM}};

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  // Only the previous 7 bits are kept; the 8th comes straight from data_in.
  logic [6:0]        win;
  logic [7:0]        win_next;
  logic [2:0]        bit_cnt;
  logic [3:0]        comma_cnt;
  logic [3:0]        comma_next;
  logic [WCNT_W-1:0] word_cnt;
  // Word shift register; the final bit is taken from data_in at completion.
  logic [WORD_W-2:0] word_sr;
  logic [WORD_W-1:0] word_full;
  logic              com_hit;
  logic              align_edge;
  logic              word_done;

  // Current-edge decode: window and word including the bit sampled now.
  always_comb begin
    win_next   = {win, data_in};
    com_hit    = (win_next == COM);
    align_edge = (bit_cnt == 3'd7);
    comma_next = comma_cnt + 4'd1;
    word_full  = {word_sr, data_in};
    word_done  = (state == ACTIVE) && (word_cnt == WORD_LAST);
  end

  // State register.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: hunt, confirm on byte boundaries, then stay locked.
  always_comb begin
    state_next = state;
    case (state)
      SEARCH: begin
        if (com_hit) begin
          state_next = (COM_LOCK == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (align_edge) begin
          if (!com_hit) begin
            state_next = SEARCH;
          end else if (comma_next == LOCK_N) begin
            state_next = ACTIVE;
          end
        end
      end
      ACTIVE:  state_next = ACTIVE;
      default: state_next = SEARCH;
    endcase
  end

  // Counters, shift registers and registered outputs.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      win         <= '0;
      bit_cnt     <= '0;
      comma_cnt   <= '0;
      word_cnt    <= '0;
      word_sr     <= '0;
      lane_out    <= '0;
      valid_out   <= 1'b0;
      word_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      win         <= win_next[6:0];
      word_strobe <= 1'b0;
      active      <= (state_next == ACTIVE);
      case (state)
        SEARCH: begin
          if (com_hit) begin
            comma_cnt <= 4'd1;
            bit_cnt   <= '0;
            word_cnt  <= '0;
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (align_edge) begin
            if (com_hit) begin
              comma_cnt <= comma_next;
              word_cnt  <= '0;
            end else begin
              comma_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          word_sr <= word_full[WORD_W-2:0];
          if (word_done) begin
            word_cnt    <= '0;
            lane_out    <= word_full;
            valid_out   <= (word_full != IDLE_WORD);
            word_strobe <= 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        default: begin
          comma_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_deserializer
// Description : Self-checking bench for lane_deserializer: table of words
//               checked through a strobe-driven scoreboard, plus hand-written
//               alignment, bit-slip and asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_deserializer;

  logic        clk;
  logic        reset;
  logic        data_in;
  logic [31:0] lane_out;
  logic        valid_out;
  logic        word_strobe;
  logic        active;

  lane_deserializer #(
    .WORD_W  (32),
    .COM     (8'hBC),
    .COM_LOCK(4)
  ) dut (
    .clk_32f    (clk),
    .reset      (reset),
    .data_in    (data_in),
    .lane_out   (lane_out),
    .valid_out  (valid_out),
    .word_strobe(word_strobe),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        valid;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [31:0] last_word   = '0;
  logic        have_last   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One serial bit; strobes are matched against the scoreboard as they occur.
  task automatic send_bit(input logic b);
    exp_t e;
    data_in = b;
    @(posedge clk);
    cyc++;
    #1;
    if (word_strobe) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(word_strobe), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("lane_out", lane_out, e.word);
        chk("valid_out", 32'(valid_out), 32'(e.valid));
        last_word = e.word;
        have_last = 1'b1;
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk("missed_strobe", 32'(word_strobe), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic v);
    exp_t e;
    e.word  = w;
    e.valid = v;
    e.cyc   = cyc + 32;
    sb.push_back(e);
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == 16 && have_last) chk("lane_hold", lane_out, last_word);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    data_in = 1'b0;
    sb.delete();
    have_last = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lock_with_commas();
    repeat (3) send_byte(8'hBC);
    for (int i = 7; i >= 1; i--) send_bit(1'((8'hBC >> i) & 8'h01));
    chk("active_before_last_bit", 32'(active), 32'd0);
    send_bit(1'b0);
    chk("active_on_last_bit", 32'(active), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h12345678, 1'b1};
    vecs[1] = '{32'hBCBCBCBC, 1'b0};
    vecs[2] = '{32'h00000000, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 1'b1};
    vecs[4] = '{32'hBCBCBCBD, 1'b1};
    vecs[5] = '{32'h000000BC, 1'b1};

    reset   = 1'b1;
    data_in = 1'b0;
    #12;
    chk("reset_lane_out", lane_out, 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_strobe", 32'(word_strobe), 32'd0);
    chk("reset_active", 32'(active), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Quiet line: nothing locks, nothing strobes.
    repeat (100) send_bit(1'b0);
    chk("idle_active", 32'(active), 32'd0);
    chk("idle_valid", 32'(valid_out), 32'd0);
    chk("idle_lane_out", lane_out, 32'd0);

    // Junk bits, lock, then the word table.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    lock_with_commas();
    chk("lock_lane_out", lane_out, 32'd0);
    for (int i = 0; i < 6; i++) send_word(vecs[i].word, vecs[i].exp_valid);
    chk("table_pending", 32'(sb.size()), 32'd0);

    // Alignment aborted by a non-comma byte, then relock.
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    chk("abort_active", 32'(active), 32'd0);
    lock_with_commas();
    send_word(32'hDEADBEEF, 1'b1);

    // Bit slip between two commas restarts the count at the second comma.
    do_reset();
    send_byte(8'hBC);
    send_bit(1'b0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    chk("slip_active", 32'(active), 32'd0);
    send_byte(8'hBC);
    chk("slip_relock", 32'(active), 32'd1);
    send_word(32'hCAFEF00D, 1'b1);

    // Asynchronous reset ten bits into a word.
    repeat (10) send_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_lane_out", lane_out, 32'd0);
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_strobe", 32'(word_strobe), 32'd0);
    chk("async_active", 32'(active), 32'd0);
    sb.delete();
    have_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    lock_with_commas();
    send_word(32'hA5A5A5A5, 1'b1);
    chk("final_pending", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
